invio_rdy_ack: RTL and testbench

//  Sender-side interface unit, directly upstream of a parametric enable register (registro).

---
 rtl/invio_rdy_ack.sv | 91 +++++++++
 tb/tb_invio_rdy_ack.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/invio_rdy_ack.sv
// Sender half of a RDY/ACK channel: a small FIFO feeding a downstream enable register,
// one message outstanding at a time, released by a modulo-2 ACK toggle.
module invio_rdy_ack #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_beta,
  output logic         rdy_out,
  input  logic         ack_in,
  output logic         err
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  state_t        state;
  logic          ack_seen;

  logic push;
  logic ack_tgl;
  logic xfer;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign ack_tgl  = ack_in ^ ack_seen;
  assign xfer     = (count != '0) &
                    ((state == IDLE) | ((state == WAIT_ACK) & ack_tgl));

  // FIFO storage; contents need no reset because the pointers do
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[tail] <= in_data;
    end
  end

  // Pointers, occupancy, ACK edge detect, send FSM and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      state    <= IDLE;
      ack_seen <= 1'b0;
      out_data <= '0;
      out_beta <= 1'b0;
      rdy_out  <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack_seen <= ack_in;
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (xfer) begin
        head <= head + AW'(1);
      end
      count <= count + CW'(push) - CW'(xfer);

      if (ack_tgl && (state == IDLE)) begin
        err <= 1'b1;
      end

      if (xfer) begin
        out_data <= mem[head];
        out_beta <= 1'b1;
        rdy_out  <= ~rdy_out;
        state    <= WAIT_ACK;
      end else begin
        out_beta <= 1'b0;
        if ((state == WAIT_ACK) && ack_tgl) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_invio_rdy_ack.sv
// Bench for invio_rdy_ack: directed vector table, hand-written corner sequences, and
// randomized traffic checked every cycle against a queue-based channel model.
module tb_invio_rdy_ack;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_beta;
  logic         rdy_out;
  logic         ack_in;
  logic         err;

  always #5 clock = ~clock;

  invio_rdy_ack #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_beta (out_beta),
    .rdy_out  (rdy_out),
    .ack_in   (ack_in),
    .err      (err)
  );

  int checks   = 0;
  int failures = 0;

  // Channel model: queued words, whether a message is outstanding, and the visible outputs
  logic [N-1:0] q [$];
  bit           m_out;
  bit           m_rdy;
  bit           m_beta;
  bit           m_err;
  bit           m_last_ack;
  logic [N-1:0] m_data;
  bit           ack_lvl;

  typedef struct {
    bit         r;
    bit         v;
    logic [7:0] d;
    bit         a;
    bit         beta;
    logic [7:0] data;
    bit         rdy;
    bit         e;
    bit         ready;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [N-1:0] d, input bit a);
    bit acked;
    bit can_push;
    if (r) begin
      q.delete();
      m_out      = 1'b0;
      m_rdy      = 1'b0;
      m_beta     = 1'b0;
      m_data     = '0;
      m_err      = 1'b0;
      m_last_ack = 1'b0;
    end else begin
      acked      = (a != m_last_ack);
      m_last_ack = a;
      can_push   = v && (q.size() < DEPTH);
      if (acked) begin
        if (!m_out) m_err = 1'b1;
        m_out = 1'b0;
      end
      if (!m_out && q.size() != 0) begin
        m_data = q.pop_front();
        m_beta = 1'b1;
        m_rdy  = ~m_rdy;
        m_out  = 1'b1;
      end else begin
        m_beta = 1'b0;
      end
      if (can_push) q.push_back(d);
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, compare 1 ns later
  task automatic step(input bit r, input bit v, input logic [N-1:0] d, input bit a);
    @(negedge clock);
    reset    = r;
    in_valid = v;
    in_data  = d;
    ack_in   = a;
    @(posedge clock);
    model_edge(r, v, d, a);
    #1;
    check("model_out_data", 32'(out_data), 32'(m_data));
    check("model_out_beta", 32'(out_beta), 32'(m_beta));
    check("model_rdy_out",  32'(rdy_out),  32'(m_rdy));
    check("model_err",      32'(err),      32'(m_err));
    check("model_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic ack_toggle();
    ack_lvl = ~ack_lvl;
    step(1'b0, 1'b0, '0, ack_lvl);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    ack_in   = 1'b0;
    ack_lvl  = 1'b0;

    //              r  v  d      a  beta data   rdy err rdy_in
    tbl[0]  = '{1, 1, 8'h33, 0, 0, 8'h00, 0, 0, 1};
    tbl[1]  = '{1, 1, 8'h33, 0, 0, 8'h00, 0, 0, 1};
    tbl[2]  = '{0, 1, 8'hA5, 0, 0, 8'h00, 0, 0, 1};
    tbl[3]  = '{0, 0, 8'h00, 0, 1, 8'hA5, 1, 0, 1};
    tbl[4]  = '{0, 0, 8'h00, 0, 0, 8'hA5, 1, 0, 1};
    tbl[5]  = '{0, 0, 8'h00, 0, 0, 8'hA5, 1, 0, 1};
    tbl[6]  = '{0, 0, 8'h00, 1, 0, 8'hA5, 1, 0, 1};
    tbl[7]  = '{0, 0, 8'h00, 1, 0, 8'hA5, 1, 0, 1};
    tbl[8]  = '{0, 0, 8'h00, 0, 0, 8'hA5, 1, 1, 1};
    tbl[9]  = '{0, 0, 8'h00, 0, 0, 8'hA5, 1, 1, 1};
    tbl[10] = '{0, 1, 8'h5A, 0, 0, 8'hA5, 1, 1, 1};
    tbl[11] = '{0, 0, 8'h00, 0, 1, 8'h5A, 0, 1, 1};
    tbl[12] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1};

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].a);
      check($sformatf("tbl%0d_beta", i),  32'(out_beta), 32'(tbl[i].beta));
      check($sformatf("tbl%0d_data", i),  32'(out_data), 32'(tbl[i].data));
      check($sformatf("tbl%0d_rdy", i),   32'(rdy_out),  32'(tbl[i].rdy));
      check($sformatf("tbl%0d_err", i),   32'(err),      32'(tbl[i].e));
      check($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].ready));
    end
    ack_lvl = 1'b0;

    // Fill: 0x01 goes out, 0x02..0x05 fill the FIFO and back-pressure the producer
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, N'(k), ack_lvl);
    step(1'b0, 1'b1, 8'hEE, ack_lvl);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_no_strobe", 32'(out_beta), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      ack_toggle();
      check($sformatf("drain%0d_data", k), 32'(out_data), 32'(k));
      check($sformatf("drain%0d_beta", k), 32'(out_beta), 32'd1);
      check($sformatf("drain%0d_ready", k), 32'(in_ready), 32'd1);
      step(1'b0, 1'b0, '0, ack_lvl);
      check($sformatf("drain%0d_beta_off", k), 32'(out_beta), 32'd0);
    end
    ack_toggle();
    check("drain_idle_no_err", 32'(err), 32'd0);

    // Simultaneous push and ACK-driven pop with two queued, across pointer wrap
    step(1'b0, 1'b1, 8'h10, ack_lvl);
    step(1'b0, 1'b1, 8'h11, ack_lvl);
    check("bb_first_sent", 32'(out_data), 32'h10);
    step(1'b0, 1'b1, 8'h12, ack_lvl);
    ack_lvl = ~ack_lvl;
    step(1'b0, 1'b1, 8'h13, ack_lvl);
    check("bb_pop_data", 32'(out_data), 32'h11);
    check("bb_pop_beta", 32'(out_beta), 32'd1);
    ack_toggle();
    check("bb_order_12", 32'(out_data), 32'h12);
    ack_toggle();
    check("bb_order_13", 32'(out_data), 32'h13);
    ack_toggle();
    check("bb_back_idle_beta", 32'(out_beta), 32'd0);

    // Reset while a message is outstanding and three more are queued
    step(1'b0, 1'b1, 8'h20, ack_lvl);
    for (int k = 1; k <= 3; k++) step(1'b0, 1'b1, N'(8'h20 + k), ack_lvl);
    ack_lvl = 1'b0;
    step(1'b1, 1'b1, 8'h77, 1'b0);
    check("rst_mid_data", 32'(out_data), 32'h00);
    check("rst_mid_rdy", 32'(rdy_out), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      check($sformatf("rst_mid_stale%0d", k), 32'(out_data), 32'h00);
      check($sformatf("rst_mid_beta%0d", k), 32'(out_beta), 32'd0);
    end

    // Randomized traffic: mostly legal ACKs, occasional stray ACK and reset
    for (int c = 0; c < 3000; c++) begin
      bit r;
      r = ($urandom_range(0, 199) == 0);
      if (r) begin
        ack_lvl = 1'b0;
      end else if (m_out ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) == 0)) begin
        ack_lvl = ~ack_lvl;
      end
      step(r, 1'($urandom_range(0, 1)), N'($urandom), ack_lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
